// File: rtl/pipe_mux_pkg.sv
// Shared types and default constants for the pipelined N:1 multiplexer.
// The occupancy encoding is visible to the top, the skid buffer and any bench.
package pipe_mux_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_state_t;

   localparam int PIPE_MUX_N     = 4;
   localparam int PIPE_MUX_W     = 32;
   localparam int PIPE_MUX_CNT_W = 16;

endpackage

// File: rtl/pipe_mux_n_if.sv
// Handshake bundle between N producers, the select source and one consumer.
// master = the environment around the mux, slave = the mux itself.
interface pipe_mux_n_if
   import pipe_mux_pkg::*;
#(
   parameter int N = PIPE_MUX_N,
   parameter int W = PIPE_MUX_W
);
   localparam int SEL_W = $clog2(N);

   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic [SEL_W-1:0] sel;
   logic [W-1:0]     out_data;
   logic             out_valid;
   logic             out_ready;
   logic             sel_err;

   modport master (
      output in_data, in_valid, sel, out_ready,
      input  in_ready, out_data, out_valid, sel_err
   );

   modport slave (
      input  in_data, in_valid, sel, out_ready,
      output in_ready, out_data, out_valid, sel_err
   );

endinterface

// File: rtl/skid_buf_w.sv
// W-bit two-entry valid/ready buffer: main output register plus one skid register.
// in_ready depends only on registered occupancy, so out_ready never reaches it combinationally.
module skid_buf_w
   import pipe_mux_pkg::*;
#(
   parameter int W = PIPE_MUX_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   occ_state_t   state;
   logic [W-1:0] skid;
   logic         accept;

   assign in_ready = (state != TWO);
   assign accept   = in_valid && in_ready;

   // NOTE: clocked state uses <= only, and the skid register is reset along with
   // the rest so a discarded beat can never resurface after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_data  <= '0;
         skid      <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (accept && out_ready) begin
                  out_data <= in_data;
               end else if (accept) begin
                  skid  <= in_data;
                  state <= TWO;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            TWO: begin
               if (out_ready) begin
                  out_data <= skid;
                  state    <= ONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_mux_n.sv
// Pipelined N:1 W-bit multiplexer with valid/ready handshake and 1-cycle latency.
// Optional accepted-beat counter on beat_cnt is built when PIPE_MUX_STATS_EN is defined.
module pipe_mux_n
   import pipe_mux_pkg::*;
#(
   parameter int N = PIPE_MUX_N,
   parameter int W = PIPE_MUX_W
`ifdef PIPE_MUX_STATS_EN
   ,
   parameter int CNT_W = PIPE_MUX_CNT_W
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_mux_n_if.slave      bus
`ifdef PIPE_MUX_STATS_EN
   ,
   output logic [CNT_W-1:0] beat_cnt
`endif
);

   localparam int SEL_W = $clog2(N);

   logic [W-1:0] sel_data;
   logic         sel_valid;
   logic         sel_ok;
   logic [N-1:0] ready_vec;
   logic         buf_ready;
   logic         accept;

   // NOTE: every always_comb output gets a default first so no latch is inferred
   // when sel matches no channel.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_ok    = 1'b0;
      ready_vec = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            sel_ok       = 1'b1;
            sel_data     = bus.in_data[i*W +: W];
            sel_valid    = bus.in_valid[i];
            ready_vec[i] = buf_ready && rst_n;
         end
      end
   end

   assign bus.in_ready = ready_vec;
   assign accept       = sel_valid && buf_ready && rst_n;

   skid_buf_w #(.W(W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (sel_data),
      .in_valid  (sel_valid),
      .in_ready  (buf_ready),
      .out_data  (bus.out_data),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sel_err <= 1'b0;
      end else begin
         bus.sel_err <= !sel_ok && (|bus.in_valid);
      end
   end

`ifdef PIPE_MUX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
      end else if (accept) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule
